axi_lite_cmd_arbiter: RTL and testbench

- Shares one command-to-AXI-Lite bridge among NUM_REQ register-access requesters, e.g. the host command parser, the FOC loop and the fault monitor.
- Round-robin arbitration; one transaction outstanding at a time; grant held until the bridge reports done.
- Sits between the requesters and the bridge's wr_*/rd_* command ports.
- Returns read data, a one-hot completion pulse and an error flag to the granted requester.

---
 rtl/axi_lite_cmd_arbiter_pkg.sv | 17 +
 rtl/axi_lite_cmd_arbiter_rr_arbiter.sv | 34 +++
 rtl/axi_lite_cmd_arbiter.sv | 153 +++++++++++++++
 tb/tb_axi_lite_cmd_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_cmd_arbiter_pkg.sv
// Shared definitions for the AXI-Lite command arbiter.
// Holds the one-hot FSM state encoding and the default widths and
// watchdog limit shared with the command bridge.
package axi_lite_cmd_arbiter_pkg;

  localparam int ARB_ADDR_W_DEF  = 8;
  localparam int ARB_DATA_W_DEF  = 32;
  localparam int ARB_TIMEOUT_DEF = 1024;

  typedef enum logic [3:0] {
    ARB_IDLE  = 4'b0001,
    ARB_ISSUE = 4'b0010,
    ARB_WAIT  = 4'b0100,
    ARB_RESP  = 4'b1000
  } arb_state_t;

endpackage

// File: rtl/axi_lite_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// the pointer, wrapping modulo NUM_REQ.
module axi_lite_cmd_arbiter_rr_arbiter
  import axi_lite_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  // Scan from the pointer upward and keep the first hit.
  always_comb begin
    int j;
    j       = 0;
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_req && req[j]) begin
        any_req  = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one command-to-AXI-Lite bridge among
// NUM_REQ register-access requesters, one transaction at a time.
// Optional WAIT watchdog: define AXI_LITE_CMD_ARB_TIMEOUT_EN.
module axi_lite_cmd_arbiter
  import axi_lite_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = ARB_ADDR_W_DEF,
  parameter int DATA_W         = ARB_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEF
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  input  logic [NUM_REQ-1:0]        req_wr_in,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_in,
  output logic [NUM_REQ-1:0]        req_done_out,
  output logic                      req_err_out,
  output logic [DATA_W-1:0]         rsp_rdata_out,
  output logic [NUM_REQ-1:0]        grant_out,
  output logic [ADDR_W-1:0]         bus_wr_addr_out,
  output logic [DATA_W-1:0]         bus_wr_data_out,
  output logic                      bus_wr_enable_out,
  input  logic                      bus_wr_done_in,
  input  logic                      bus_wr_busy_in,
  output logic [ADDR_W-1:0]         bus_rd_addr_out,
  output logic                      bus_rd_enable_out,
  input  logic [DATA_W-1:0]         bus_rd_data_in,
  input  logic                      bus_rd_done_in,
  input  logic                      bus_rd_busy_in
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] pick_grant;
  logic               any_req;
  logic               rw;
  logic               issue_ok;
  logic               done_match;
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr_in[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata_in[g*DATA_W +: DATA_W];
  end

  axi_lite_cmd_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (req_valid_in),
    .ptr     (rr_ptr),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // Only the busy/done pair matching the latched direction matters.
  assign issue_ok   = rw ? !bus_wr_busy_in : !bus_rd_busy_in;
  assign done_match = rw ? bus_wr_done_in : bus_rd_done_in;
  assign ptr_next   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Strobes are high only in the ISSUE cycle the bridge is free, so each
  // transaction produces exactly one strobe.
  assign bus_wr_enable_out = (state == ARB_ISSUE) &&  rw && !bus_wr_busy_in;
  assign bus_rd_enable_out = (state == ARB_ISSUE) && !rw && !bus_rd_busy_in;

`ifdef AXI_LITE_CMD_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        err_q;
  assign req_err_out = err_q;
`else
  // Without the watchdog a transaction can never fail; the comparison is a
  // constant zero that keeps the watchdog limit referenced.
  assign req_err_out = (TIMEOUT_CYCLES < 0);
`endif

  // Arbitration FSM: grant, issue one strobe, wait for completion, report.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ARB_IDLE;
      rr_ptr          <= '0;
      grant_idx       <= '0;
      grant_out       <= '0;
      rw              <= 1'b0;
      bus_wr_addr_out <= '0;
      bus_rd_addr_out <= '0;
      bus_wr_data_out <= '0;
      req_done_out    <= '0;
      rsp_rdata_out   <= '0;
`ifdef AXI_LITE_CMD_ARB_TIMEOUT_EN
      wait_cnt        <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      req_done_out <= '0;
`ifdef AXI_LITE_CMD_ARB_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_out       <= pick_grant;
            grant_idx       <= pick_idx;
            rw              <= req_wr_in[pick_idx];
            bus_wr_addr_out <= addr_arr[pick_idx];
            bus_rd_addr_out <= addr_arr[pick_idx];
            bus_wr_data_out <= wdata_arr[pick_idx];
            state           <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (issue_ok) begin
            state <= ARB_WAIT;
`ifdef AXI_LITE_CMD_ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ARB_WAIT: begin
          if (done_match) begin
            req_done_out  <= grant_out;
            rsp_rdata_out <= rw ? '0 : bus_rd_data_in;
            state         <= ARB_RESP;
`ifdef AXI_LITE_CMD_ARB_TIMEOUT_EN
          end else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            req_done_out  <= grant_out;
            rsp_rdata_out <= '0;
            err_q         <= 1'b1;
            state         <= ARB_RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        ARB_RESP: begin
          grant_out <= '0;
          rr_ptr    <= ptr_next;
          state     <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Self-checking bench for axi_lite_cmd_arbiter: transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
// Watchdog scenario only when AXI_LITE_CMD_ARB_TIMEOUT_EN is defined.
module tb_axi_lite_cmd_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int T  = 16;

  logic          sys_clk;
  logic          reset_n;
  logic [N-1:0]  req_valid_in;
  logic [N-1:0]  req_wr_in;
  logic [N*AW-1:0] req_addr_in;
  logic [N*DW-1:0] req_wdata_in;
  logic [N-1:0]  req_done_out;
  logic          req_err_out;
  logic [DW-1:0] rsp_rdata_out;
  logic [N-1:0]  grant_out;
  logic [AW-1:0] bus_wr_addr_out;
  logic [DW-1:0] bus_wr_data_out;
  logic          bus_wr_enable_out;
  logic          bus_wr_done_in;
  logic          bus_wr_busy_in;
  logic [AW-1:0] bus_rd_addr_out;
  logic          bus_rd_enable_out;
  logic [DW-1:0] bus_rd_data_in;
  logic          bus_rd_done_in;
  logic          bus_rd_busy_in;

  axi_lite_cmd_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .req_valid_in(req_valid_in), .req_wr_in(req_wr_in),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .req_done_out(req_done_out), .req_err_out(req_err_out),
    .rsp_rdata_out(rsp_rdata_out), .grant_out(grant_out),
    .bus_wr_addr_out(bus_wr_addr_out), .bus_wr_data_out(bus_wr_data_out),
    .bus_wr_enable_out(bus_wr_enable_out), .bus_wr_done_in(bus_wr_done_in),
    .bus_wr_busy_in(bus_wr_busy_in), .bus_rd_addr_out(bus_rd_addr_out),
    .bus_rd_enable_out(bus_rd_enable_out), .bus_rd_data_in(bus_rd_data_in),
    .bus_rd_done_in(bus_rd_done_in), .bus_rd_busy_in(bus_rd_busy_in)
  );

  int checks = 0;
  int errors = 0;
  int done_log[$];

  // bridge control knobs (written only by the stimulus process)
  bit            bridge_mute = 0;
  int            bridge_lat  = 1;
  logic [DW-1:0] resp_data   = '0;
  bit            stray_wr    = 0;
  bit            stray_rd    = 0;

  initial begin
    sys_clk = 0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // owner: requester being served (-1 = none); issued: its strobe went out;
  // fin: completion being reported this cycle.
  int            m_own = -1;
  int            m_ptr = 0;
  int            m_wcnt = 0;
  bit            m_issued = 0, m_fin = 0, m_err = 0, m_rw = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;

  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_own = -1; m_ptr = 0; m_wcnt = 0; m_issued = 0; m_fin = 0; m_err = 0;
      m_rw = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_fin) begin
      m_fin = 0;
      m_ptr = (m_own + 1) % N;
      m_own = -1;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_own < 0 && req_valid_in[j]) begin
          m_own   = j;
          m_rw    = req_wr_in[j];
          m_addr  = req_addr_in[j*AW +: AW];
          m_wdata = req_wdata_in[j*DW +: DW];
        end
      end
    end else if (!m_issued) begin
      if (m_rw ? !bus_wr_busy_in : !bus_rd_busy_in) begin
        m_issued = 1;
        m_wcnt   = 0;
      end
    end else begin
      if (m_rw ? bus_wr_done_in : bus_rd_done_in) begin
        m_fin = 1; m_err = 0; m_issued = 0;
        m_rdata = m_rw ? '0 : bus_rd_data_in;
      end
`ifdef AXI_LITE_CMD_ARB_TIMEOUT_EN
      else if (m_wcnt == T - 1) begin
        m_fin = 1; m_err = 1; m_issued = 0; m_rdata = '0;
      end
`endif
      else m_wcnt++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      logic [N-1:0] e_grant, e_done;
      bit e_wr, e_rd, active;
      @(negedge sys_clk);
      active  = (m_own >= 0);
      e_grant = active ? N'(1 << m_own) : '0;
      e_done  = (active && m_fin) ? N'(1 << m_own) : '0;
      e_wr    = active && !m_issued && !m_fin &&  m_rw && !bus_wr_busy_in;
      e_rd    = active && !m_issued && !m_fin && !m_rw && !bus_rd_busy_in;
      chk("grant_out", 64'(grant_out), 64'(e_grant));
      chk("req_done_out", 64'(req_done_out), 64'(e_done));
      chk("req_err_out", 64'(req_err_out), 64'(m_fin && m_err));
      chk("rsp_rdata_out", 64'(rsp_rdata_out), 64'(m_rdata));
      chk("bus_wr_enable_out", 64'(bus_wr_enable_out), 64'(e_wr));
      chk("bus_rd_enable_out", 64'(bus_rd_enable_out), 64'(e_rd));
      chk("bus_wr_addr_out", 64'(bus_wr_addr_out), 64'(m_addr));
      chk("bus_rd_addr_out", 64'(bus_rd_addr_out), 64'(m_addr));
      chk("bus_wr_data_out", 64'(bus_wr_data_out), 64'(m_wdata));
      for (int i = 0; i < N; i++)
        if (req_done_out[i]) done_log.push_back(i);
    end
  end

  // Bridge responder: a strobe seen in a cycle yields the matching done
  // bridge_lat cycles later, unless muted.
  initial begin
    int  cnt;
    bit  fw, fr, pw, aw_d, ar_d;
    cnt = 0; pw = 0;
    bus_wr_done_in = 0; bus_rd_done_in = 0; bus_rd_data_in = '0;
    forever begin
      @(negedge sys_clk);
      fw = bus_wr_enable_out;
      fr = bus_rd_enable_out;
      @(posedge sys_clk);
      #2;
      aw_d = 0; ar_d = 0;
      if ((fw || fr) && !bridge_mute) begin
        cnt = bridge_lat;
        pw  = fw;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (pw) aw_d = 1; else ar_d = 1;
        end
      end
      bus_wr_done_in = aw_d | stray_wr;
      bus_rd_done_in = ar_d | stray_rd;
      bus_rd_data_in = resp_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_in[i]          = v;
    req_wr_in[i]             = wr;
    req_addr_in[i*AW +: AW]  = a;
    req_wdata_in[i*DW +: DW] = d;
  endtask

  // which: 0 wr strobe, 1 rd strobe, 2 done pulse, 3 grant nonzero
  task automatic wait_for(input int which, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge sys_clk);
      case (which)
        0: ok = bus_wr_enable_out;
        1: ok = bus_rd_enable_out;
        2: ok = (req_done_out != 0);
        default: ok = (grant_out != 0);
      endcase
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_for event=%0d actual=none required=within_%0d_cycles", which, budget);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    reset_n = 0;
    req_valid_in = '0; req_wr_in = '0; req_addr_in = '0; req_wdata_in = '0;
    bus_wr_busy_in = 0; bus_rd_busy_in = 0;
    repeat (3) tick();
    @(negedge sys_clk);
    chk("reset_grant", 64'(grant_out), 64'h0);
    chk("reset_done", 64'(req_done_out), 64'h0);
    chk("reset_rdata", 64'(rsp_rdata_out), 64'h0);
    tick();
    reset_n = 1;
    tick();

    // fairness: all four held valid from pointer 0
    set_req(0, 1, 1, 8'h40, 32'h0000_00A0);
    set_req(1, 1, 0, 8'h41, 32'h0);
    set_req(2, 1, 1, 8'h42, 32'h0000_00A2);
    set_req(3, 1, 0, 8'h43, 32'h0);
    resp_data = 32'h0BAD_F00D;
    done_log.delete();
    for (int k = 0; k < 5; k++) wait_for(2, 50);
    tick();
    req_valid_in = '0;
    chk("fair_count", 64'(done_log.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      int exp_i;
      exp_i = (k == 4) ? 0 : k;
      chk("fair_order", (k < done_log.size()) ? 64'(done_log[k]) : 64'hFFFF, 64'(exp_i));
    end
    repeat (2) tick();

    // single write
    set_req(0, 1, 1, 8'h10, 32'hDEAD_BEEF);
    wait_for(0, 20);
    chk("wr_addr", 64'(bus_wr_addr_out), 64'h10);
    chk("wr_data", 64'(bus_wr_data_out), 64'hDEAD_BEEF);
    wait_for(2, 20);
    chk("wr_done", 64'(req_done_out), 64'b0001);
    chk("wr_err", 64'(req_err_out), 64'h0);
    tick();
    set_req(0, 0, 0, 8'h0, 32'h0);
    tick();

    // single read
    resp_data = 32'h1234_5678;
    set_req(2, 1, 0, 8'h24, 32'h0);
    wait_for(1, 20);
    chk("rd_addr", 64'(bus_rd_addr_out), 64'h24);
    wait_for(2, 20);
    chk("rd_done", 64'(req_done_out), 64'b0100);
    chk("rd_data", 64'(rsp_rdata_out), 64'h1234_5678);
    tick();
    set_req(2, 0, 0, 8'h0, 32'h0);
    tick();
    chk("rd_data_hold", 64'(rsp_rdata_out), 64'h1234_5678);

    // busy stall of five ISSUE cycles
    bus_rd_busy_in = 1;
    resp_data = 32'h5A5A_0001;
    set_req(1, 1, 0, 8'h33, 32'h0);
    wait_for(3, 20);
    for (int k = 0; k < 5; k++) begin
      chk("stall_no_enable", 64'(bus_rd_enable_out), 64'h0);
      if (k < 4) @(negedge sys_clk);
    end
    tick();
    bus_rd_busy_in = 0;
    @(negedge sys_clk);
    chk("stall_enable", 64'(bus_rd_enable_out), 64'h1);
    wait_for(2, 20);
    chk("stall_done", 64'(req_done_out), 64'b0010);
    tick();
    set_req(1, 0, 0, 8'h0, 32'h0);
    tick();

    // requester drops valid mid-transaction; stray read done during a write
    bridge_lat = 4;
    set_req(3, 1, 1, 8'h77, 32'hFEED_0003);
    wait_for(0, 20);
    tick();
    set_req(3, 0, 1, 8'h77, 32'hFEED_0003);
    stray_rd = 1;
    tick();
    stray_rd = 0;
    wait_for(2, 20);
    chk("drop_done", 64'(req_done_out), 64'b1000);
    chk("drop_wr_rdata", 64'(rsp_rdata_out), 64'h0);
    bridge_lat = 1;
    tick();

    // done while idle and during ISSUE is ignored
    stray_rd = 1;
    bus_rd_busy_in = 1;
    set_req(0, 1, 0, 8'h05, 32'h0);
    resp_data = 32'h0000_0E0E;
    repeat (3) tick();
    stray_rd = 0;
    tick();
    bus_rd_busy_in = 0;
    wait_for(2, 20);
    chk("stray_done", 64'(req_done_out), 64'b0001);
    tick();
    set_req(0, 0, 0, 8'h0, 32'h0);
    tick();

    // reset while req2 waits; req1 and req3 pending, pointer returns to 0
    bridge_mute = 1;
    set_req(2, 1, 0, 8'h22, 32'h0);
    wait_for(1, 20);
    tick();
    set_req(1, 1, 0, 8'h11, 32'h0);
    set_req(3, 1, 1, 8'h13, 32'h3333_3333);
    repeat (2) tick();
    reset_n = 0;
    set_req(2, 0, 0, 8'h0, 32'h0);
    @(negedge sys_clk);
    chk("rst_mid_grant", 64'(grant_out), 64'h0);
    chk("rst_mid_rd_en", 64'(bus_rd_enable_out), 64'h0);
    chk("rst_mid_rdata", 64'(rsp_rdata_out), 64'h0);
    chk("rst_mid_addr", 64'(bus_rd_addr_out), 64'h0);
    tick();
    reset_n = 1;
    bridge_mute = 0;
    wait_for(3, 20);
    chk("rst_first_grant", 64'(grant_out), 64'b0010);
    wait_for(2, 20);
    chk("rst_done1", 64'(req_done_out), 64'b0010);
    tick();
    set_req(1, 0, 0, 8'h0, 32'h0);
    wait_for(2, 20);
    chk("rst_done3", 64'(req_done_out), 64'b1000);
    tick();
    set_req(3, 0, 0, 8'h0, 32'h0);
    tick();

`ifdef AXI_LITE_CMD_ARB_TIMEOUT_EN
    // watchdog: bridge never answers
    bridge_mute = 1;
    resp_data = 32'hCAFE_F00D;
    set_req(0, 1, 0, 8'h55, 32'h0);
    wait_for(1, 20);
    n = 0;
    for (int k = 0; k < 100 && req_done_out == 0; k++) begin
      @(negedge sys_clk);
      n++;
    end
    chk("to_latency", 64'(n), 64'd17);
    chk("to_done", 64'(req_done_out), 64'b0001);
    chk("to_err", 64'(req_err_out), 64'h1);
    chk("to_rdata", 64'(rsp_rdata_out), 64'h0);
    tick();
    set_req(0, 0, 0, 8'h0, 32'h0);
    bridge_mute = 0;
    stray_rd = 1;
    tick();
    stray_rd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      chk("to_late_done", 64'(req_done_out), 64'h0);
    end
    tick();
`else
    n = 0;
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=hung required=finish");
    $fatal(1, "global timeout");
  end

endmodule
